fu_mdu: RTL and testbench

- Parametrised, multi-cycle execution unit for the NPC EXU; replaces the purely combinational ALU stage.
- Single-cycle ALU ops and RV32M multiply/divide share one valid/ready input and one valid/ready output.
- Operand selection by instruction type is retained.
- Adds a registered result, back-pressure, flush, iterative MUL/DIV, and shift amounts masked to log2(XLEN) bits.

---
 rtl/fu_mdu_pkg.sv | 52 +++++
 rtl/mdu_iter.sv | 69 ++++++
 rtl/fu_mdu.sv | 180 ++++++++++++++++++
 tb/tb_fu_mdu.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_mdu_pkg.sv
// Shared encodings for the NPC execution unit: instruction classes, ALU/MDU
// operation codes and the fu_mdu sequencing states.
package fu_mdu_pkg;

  localparam int INST_NOP   = 0;
  localparam int INST_RR    = 1;
  localparam int INST_RI    = 2;
  localparam int INST_LUI   = 3;
  localparam int INST_AUIPC = 4;
  localparam int INST_JAL   = 5;
  localparam int INST_JALR  = 6;

  localparam int ALU_OP_NOP   = 0;
  localparam int ALU_OP_ADD   = 1;
  localparam int ALU_OP_SUB   = 2;
  localparam int ALU_OP_XOR   = 3;
  localparam int ALU_OP_OR    = 4;
  localparam int ALU_OP_AND   = 5;
  localparam int ALU_OP_SLL   = 6;
  localparam int ALU_OP_SRL   = 7;
  localparam int ALU_OP_SRA   = 8;
  localparam int ALU_OP_SLT   = 9;
  localparam int ALU_OP_SLTU  = 10;
  localparam int ALU_OP_LUI   = 11;
  localparam int ALU_OP_AUIPC = 12;
  localparam int ALU_OP_JUMP  = 13;

  localparam int MDU_OP_MUL    = 16;
  localparam int MDU_OP_MULH   = 17;
  localparam int MDU_OP_MULHSU = 18;
  localparam int MDU_OP_MULHU  = 19;
  localparam int MDU_OP_DIV    = 20;
  localparam int MDU_OP_DIVU   = 21;
  localparam int MDU_OP_REM    = 22;
  localparam int MDU_OP_REMU   = 23;

  typedef enum logic [1:0] {
    FU_IDLE = 2'd0,
    FU_MUL  = 2'd1,
    FU_DIV  = 2'd2,
    FU_DONE = 2'd3
  } fu_state_e;

  function automatic logic is_mul_op(input int op);
    return (op >= MDU_OP_MUL) && (op <= MDU_OP_MULHU);
  endfunction

  function automatic logic is_div_op(input int op);
    return (op >= MDU_OP_DIV) && (op <= MDU_OP_REMU);
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply / restoring divide on XLEN-bit magnitudes.
// One adder serves both modes; done_o flags the cycle of the final step.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            start_i,
  input  logic            is_div_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  localparam int CW = $clog2(XLEN) + 1;

  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] acc, mq, md;
  logic            mode_div;
  logic [XLEN+1:0] add_a, add_b, sum;
  logic [XLEN:0]   sum_m;
  logic [XLEN-1:0] acc_nx, mq_nx;

  // div: trial-subtract divisor from {rem, next dividend bit}; mul: acc + md
  always_comb begin
    add_a  = mode_div ? {1'b0, acc, mq[XLEN-1]} : {2'b00, acc};
    add_b  = mode_div ? ~{2'b00, md} : {2'b00, md};
    sum    = add_a + add_b + {{(XLEN+1){1'b0}}, mode_div};
    sum_m  = '0;
    acc_nx = '0;
    mq_nx  = '0;
    if (mode_div) begin
      acc_nx = sum[XLEN+1] ? add_a[XLEN-1:0] : sum[XLEN-1:0];
      mq_nx  = {mq[XLEN-2:0], ~sum[XLEN+1]};
    end else begin
      sum_m           = mq[0] ? sum[XLEN:0] : {1'b0, acc};
      {acc_nx, mq_nx} = {sum_m, mq[XLEN-1:1]};
    end
  end

  assign done_o = (cnt == CW'(1));
  assign hi_o   = acc_nx;
  assign lo_o   = mq_nx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      acc      <= '0;
      mq       <= '0;
      md       <= '0;
      mode_div <= 1'b0;
    end else if (flush_i) begin
      cnt <= '0;
    end else if (start_i) begin
      cnt      <= CW'(XLEN);
      acc      <= '0;
      mq       <= opa_i;
      md       <= opb_i;
      mode_div <= is_div_i;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
      acc <= acc_nx;
      mq  <= mq_nx;
    end
  end

endmodule

// File: rtl/fu_mdu.sv
// NPC execution unit: operand select, single-cycle ALU, iterative RV32M
// multiply/divide, valid/ready on both sides and a registered result.
module fu_mdu
  import fu_mdu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int OP_W   = 5,
  parameter int TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [TYPE_W-1:0] inst_type_i,
  input  logic [OP_W-1:0]   alu_op_i,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [XLEN-1:0]   imm_i,
  input  logic [XLEN-1:0]   rdata1_i,
  input  logic [XLEN-1:0]   rdata2_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   result_o
);
  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  fu_state_e       state, state_nx;
  int              op, ityp, opq;
  logic [XLEN-1:0] op1, op2, alu_res, result_q, special_res;
  logic [XLEN-1:0] mag_a, mag_b, mul_res, div_res;
  logic [OP_W-1:0] op_q;
  logic            is_nop, is_mul, is_div, div_special, sgn_a, sgn_b, neg_a, neg_b;
  logic            neg_x_q, neg_a_q, accept, start, iter_done;
  logic [XLEN-1:0] iter_hi, iter_lo;
  logic [2*XLEN-1:0] prod, prod_s;

  always_comb begin
    op   = int'(alu_op_i);
    ityp = int'(inst_type_i);
    op1  = '0;
    op2  = '0;
    case (ityp)
      INST_RR:             begin op1 = rdata1_i; op2 = rdata2_i; end
      INST_RI:             begin op1 = rdata1_i; op2 = imm_i;    end
      INST_LUI:            op2 = imm_i;
      INST_AUIPC:          begin op1 = pc_i;     op2 = imm_i;    end
      INST_JAL, INST_JALR: op1 = pc_i;
      default: ;
    endcase
    is_nop = (ityp == INST_NOP) || (op == ALU_OP_NOP);
    if (is_nop) begin
      op1 = '0;
      op2 = '0;
    end
  end

  always_comb begin
    alu_res = '0;
    case (op)
      ALU_OP_ADD:   alu_res = op1 + op2;
      ALU_OP_SUB:   alu_res = op1 - op2;
      ALU_OP_XOR:   alu_res = op1 ^ op2;
      ALU_OP_OR:    alu_res = op1 | op2;
      ALU_OP_AND:   alu_res = op1 & op2;
      ALU_OP_SLL:   alu_res = op1 << op2[SHW-1:0];
      ALU_OP_SRL:   alu_res = op1 >> op2[SHW-1:0];
      ALU_OP_SRA:   alu_res = $signed(op1) >>> op2[SHW-1:0];
      ALU_OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      ALU_OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      ALU_OP_LUI,
      ALU_OP_AUIPC: alu_res = op1 + op2;
      ALU_OP_JUMP:  alu_res = op1 + XLEN'(4);
      default:      alu_res = '0;
    endcase
    if (is_nop) alu_res = '0;
  end

  // The iterative core works on magnitudes; signs are reapplied on completion.
  always_comb begin
    is_mul = !is_nop && is_mul_op(op);
    is_div = !is_nop && is_div_op(op);
    sgn_a  = (op == MDU_OP_MUL) || (op == MDU_OP_MULH) || (op == MDU_OP_MULHSU) ||
             (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    sgn_b  = (op == MDU_OP_MUL) || (op == MDU_OP_MULH) ||
             (op == MDU_OP_DIV) || (op == MDU_OP_REM);
    neg_a  = sgn_a && op1[XLEN-1];
    neg_b  = sgn_b && op2[XLEN-1];
    mag_a  = neg_a ? -op1 : op1;
    mag_b  = neg_b ? -op2 : op2;
    special_res = '0;
    div_special = 1'b0;
    if (op2 == '0) begin
      div_special = 1'b1;
      special_res = (op == MDU_OP_DIV || op == MDU_OP_DIVU) ? '1 : op1;
    end else if ((op == MDU_OP_DIV || op == MDU_OP_REM) && op1 == MIN && op2 == '1) begin
      div_special = 1'b1;
      special_res = (op == MDU_OP_DIV) ? MIN : '0;
    end
  end

  always_comb begin
    opq     = int'(op_q);
    prod    = {iter_hi, iter_lo};
    prod_s  = neg_x_q ? -prod : prod;
    mul_res = (opq == MDU_OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    if (opq == MDU_OP_DIV || opq == MDU_OP_DIVU) div_res = neg_x_q ? -iter_lo : iter_lo;
    else                                         div_res = neg_a_q ? -iter_hi : iter_hi;
  end

  assign ready_o = !flush_i && ((state == FU_IDLE) || (state == FU_DONE && ready_i));
  assign accept  = valid_i && ready_o;
  assign valid_o = (state == FU_DONE);
  assign result_o = result_q;

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    if (flush_i) begin
      state_nx = FU_IDLE;
    end else begin
      case (state)
        FU_IDLE, FU_DONE: begin
          if (accept) begin
            if (is_mul) begin
              state_nx = FU_MUL;
              start    = 1'b1;
            end else if (is_div && !div_special) begin
              state_nx = FU_DIV;
              start    = 1'b1;
            end else begin
              state_nx = FU_DONE;
            end
          end else if (state == FU_DONE && ready_i) begin
            state_nx = FU_IDLE;
          end
        end
        FU_MUL, FU_DIV: if (iter_done) state_nx = FU_DONE;
        default: state_nx = FU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FU_IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      op_q     <= '0;
      neg_x_q  <= 1'b0;
      neg_a_q  <= 1'b0;
    end else if (!flush_i) begin
      if (accept) begin
        op_q    <= alu_op_i;
        neg_x_q <= neg_a ^ neg_b;
        neg_a_q <= neg_a;
        if (!start) result_q <= is_div ? special_res : alu_res;
      end else if ((state == FU_MUL || state == FU_DIV) && iter_done) begin
        result_q <= (state == FU_MUL) ? mul_res : div_res;
      end
    end
  end

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .flush_i  (flush_i),
    .start_i  (start),
    .is_div_i (is_div),
    .opa_i    (mag_a),
    .opb_i    (mag_b),
    .done_o   (iter_done),
    .hi_o     (iter_hi),
    .lo_o     (iter_lo)
  );

endmodule

// File: tb/tb_fu_mdu.sv
// Scenario bench for fu_mdu: expected results are queued at acceptance and
// matched in order when a result transfers.
module tb_fu_mdu;
  import fu_mdu_pkg::*;

  localparam int XLEN = 32, OP_W = 5, TYPE_W = 3;

  logic              clk = 1'b0, rst = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b1;
  logic              ready_o, valid_o;
  logic [TYPE_W-1:0] inst_type_i = '0;
  logic [OP_W-1:0]   alu_op_i = '0;
  logic [XLEN-1:0]   pc_i = '0, imm_i = '0, rdata1_i = '0, rdata2_i = '0, result_o;

  int n_vec = 0, n_bad = 0, cyc = 0, n_xfer = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    int typ; int op;
    logic [XLEN-1:0] a, b, imm, pc, exp;
  } vec_t;

  fu_mdu #(.XLEN(XLEN), .OP_W(OP_W), .TYPE_W(TYPE_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .inst_type_i(inst_type_i), .alu_op_i(alu_op_i), .pc_i(pc_i), .imm_i(imm_i),
    .rdata1_i(rdata1_i), .rdata2_i(rdata2_i), .valid_o(valid_o), .ready_i(ready_i),
    .result_o(result_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: a transfer happens at the next edge when valid_o && ready_i
  always @(negedge clk) begin
    if (!rst && !flush_i && valid_o && ready_i) begin
      logic [XLEN-1:0] e;
      n_vec  = n_vec + 1;
      n_xfer = n_xfer + 1;
      if (exp_q.size() == 0) begin
        n_bad = n_bad + 1;
        $display("FAIL scoreboard: unexpected result %h", result_o);
      end else begin
        e = exp_q.pop_front();
        if (result_o !== e) begin
          n_bad = n_bad + 1;
          $display("FAIL scoreboard: result %h expected %h", result_o, e);
        end
      end
    end
  end

  task automatic issue(input int typ, input int op, input logic [XLEN-1:0] a, b, imm, pc,
                       input logic [XLEN-1:0] exp, input bit push);
    bit acc = 0;
    inst_type_i = TYPE_W'(typ);
    alu_op_i    = OP_W'(op);
    rdata1_i    = a;
    rdata2_i    = b;
    imm_i       = imm;
    pc_i        = pc;
    valid_i     = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      if (ready_o) begin
        acc = 1;
        if (push) exp_q.push_back(exp);
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    if (!acc) begin
      n_vec++; n_bad++;
      $display("FAIL issue: request op %0d not accepted, ready_o %b required 1", op, ready_o);
    end
  endtask

  task automatic drain(output bit ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({ready_o, valid_o, result_o} !== {1'b1, 1'b0, 32'h0}) begin
      n_bad++;
      $display("FAIL reset: ready/valid/result %b/%b/%h required 1/0/0", ready_o, valid_o, result_o);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_add();
    issue(INST_RR, ALU_OP_ADD, 7, 5, 0, 0, 12, 1);
    @(negedge clk);
    n_vec++;
    if (valid_o !== 1'b1 || result_o !== 32'd12) begin
      n_bad++;
      $display("FAIL add_latency: valid %b result %h required 1 0000000c", valid_o, result_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int c0 = cyc, x0 = n_xfer;
    for (int i = 0; i < 4; i++) issue(INST_RR, ALU_OP_ADD, i, 100, 0, 0, 32'(100 + i), 1);
    @(negedge clk); #1;
    n_vec++;
    if (n_xfer - x0 != 4 || cyc - c0 != 4) begin
      n_bad++;
      $display("FAIL back_to_back: %0d results in %0d cycles required 4 in 4", n_xfer - x0, cyc - c0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_alu();
    vec_t v[11];
    bit ok;
    v = '{
      '{INST_RI,    ALU_OP_SRA,   32'h8000_0000, 0, 32'h24, 0, 32'hF800_0000},
      '{INST_RR,    ALU_OP_SLT,   32'hFFFF_FFFF, 1, 0, 0, 32'h1},
      '{INST_RR,    ALU_OP_SLTU,  32'hFFFF_FFFF, 1, 0, 0, 32'h0},
      '{INST_RR,    ALU_OP_SUB,   5, 7, 0, 0, 32'hFFFF_FFFE},
      '{INST_RR,    ALU_OP_SLL,   3, 33, 0, 0, 32'h6},
      '{INST_RR,    ALU_OP_SRL,   32'h8000_0000, 31, 0, 0, 32'h1},
      '{INST_LUI,   ALU_OP_LUI,   32'hDEAD, 0, 32'h1234_5000, 0, 32'h1234_5000},
      '{INST_AUIPC, ALU_OP_AUIPC, 0, 0, 32'h2000, 32'h100, 32'h2100},
      '{INST_JAL,   ALU_OP_JUMP,  0, 0, 0, 32'h200, 32'h204},
      '{INST_NOP,   ALU_OP_ADD,   9, 9, 9, 9, 32'h0},
      '{INST_RR,    31,           9, 9, 0, 0, 32'h0}
    };
    foreach (v[i]) issue(v[i].typ, v[i].op, v[i].a, v[i].b, v[i].imm, v[i].pc, v[i].exp, 1);
    drain(ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL alu_drain: %0d results outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_mul();
    int n = 0;
    bit ok;
    issue(INST_RR, MDU_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFE, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++;
      if (valid_o) break;
    end
    n_vec++;
    if (n != 33) begin n_bad++; $display("FAIL mul_latency: %0d cycles required 33", n); end
    @(posedge clk); #1;
    issue(INST_RR, MDU_OP_MUL,    32'hFFFF_FFFD, 7, 0, 0, 32'hFFFF_FFEB, 1);
    issue(INST_RR, MDU_OP_MULH,   32'hFFFF_FFFD, 7, 0, 0, 32'hFFFF_FFFF, 1);
    issue(INST_RR, MDU_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'hFFFF_FFFF, 1);
    issue(INST_RR, MDU_OP_MULH,   32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 1);
    drain(ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL mul_drain: %0d results outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_div();
    int n = 0;
    bit ok;
    issue(INST_RR, MDU_OP_DIVU, 32'h1234, 0, 0, 0, 32'hFFFF_FFFF, 1);
    @(negedge clk);
    n_vec++;
    if (valid_o !== 1'b1) begin n_bad++; $display("FAIL divzero_latency: valid %b required 1", valid_o); end
    @(posedge clk); #1;
    issue(INST_RR, MDU_OP_DIV, 32'hFFFF_FFF9, 2, 0, 0, 32'hFFFF_FFFD, 1);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); n++;
      if (valid_o) break;
    end
    n_vec++;
    if (n != 33) begin n_bad++; $display("FAIL div_latency: %0d cycles required 33", n); end
    @(posedge clk); #1;
    issue(INST_RR, MDU_OP_REM,  32'hFFFF_FFF9, 2, 0, 0, 32'hFFFF_FFFF, 1);
    issue(INST_RR, MDU_OP_DIVU, 100, 7, 0, 0, 14, 1);
    issue(INST_RR, MDU_OP_REMU, 100, 7, 0, 0, 2, 1);
    issue(INST_RR, MDU_OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h8000_0000, 1);
    issue(INST_RR, MDU_OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'h0, 1);
    issue(INST_RR, MDU_OP_REMU, 5, 0, 0, 0, 5, 1);
    issue(INST_RR, MDU_OP_DIV,  100, 32'hFFFF_FFF9, 0, 0, 32'hFFFF_FFF2, 1);
    issue(INST_RR, MDU_OP_REM,  100, 32'hFFFF_FFF9, 0, 0, 32'h2, 1);
    drain(ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL div_drain: %0d results outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_hold();
    int x0;
    logic [XLEN-1:0] r0;
    ready_i = 1'b0;
    issue(INST_RR, ALU_OP_ADD, 3, 4, 0, 0, 7, 1);
    x0 = n_xfer;
    @(negedge clk);
    r0 = result_o;
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || result_o !== r0 || r0 !== 32'd7) begin
        n_bad++;
        $display("FAIL hold: valid %b ready %b result %h required 1 0 00000007", valid_o, ready_o, result_o);
      end
      @(negedge clk);
    end
    ready_i = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (n_xfer - x0 != 1 || valid_o !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: %0d transfers valid %b required 1 transfer valid 0", n_xfer - x0, valid_o);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    bit seen = 0, ok;
    issue(INST_RR, MDU_OP_DIVU, 1000, 3, 0, 0, 0, 0);
    repeat (9) @(posedge clk);
    #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    n_vec++;
    if (seen) begin n_bad++; $display("FAIL flush_div: valid_o 1 seen required 0"); end
    @(posedge clk); #1;
    // a request offered during flush must not be taken
    inst_type_i = TYPE_W'(INST_RR); alu_op_i = OP_W'(ALU_OP_ADD);
    rdata1_i = 1; rdata2_i = 1; valid_i = 1'b1; flush_i = 1'b1;
    @(negedge clk);
    n_vec++;
    if (ready_o !== 1'b0) begin n_bad++; $display("FAIL flush_ready: ready_o %b required 0", ready_o); end
    @(posedge clk); #1 valid_i = 1'b0; flush_i = 1'b0;
    @(negedge clk);
    n_vec++;
    if (valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_accept: valid_o %b required 0", valid_o); end
    @(posedge clk); #1;
    issue(INST_RR, ALU_OP_ADD, 1, 1, 0, 0, 2, 1);
    drain(ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL flush_drain: %0d results outstanding required 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid_mul();
    bit seen = 0, ok;
    issue(INST_RR, MDU_OP_MUL, 5, 6, 0, 0, 0, 0);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({valid_o, result_o, ready_o} !== {1'b0, 32'h0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid_mul: valid/result/ready %b/%h/%b required 0/0/1", valid_o, result_o, ready_o);
    end
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (valid_o) seen = 1;
    end
    n_vec++;
    if (seen) begin n_bad++; $display("FAIL reset_discard: valid_o 1 seen required 0"); end
    @(posedge clk); #1;
    issue(INST_RR, ALU_OP_ADD, 2, 2, 0, 0, 4, 1);
    drain(ok);
    n_vec++;
    if (!ok) begin n_bad++; $display("FAIL reset_drain: %0d results outstanding required 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_alu();
    test_mul();
    test_div();
    test_hold();
    test_flush();
    test_reset_mid_mul();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
